aes_enc_iter: RTL and testbench

- Iterative AES block-encryption engine: one full AES round per clock, round keys expanded on the fly.
- Successor to the single-shot last-round datapath. Generalised to AES-128 or AES-256 via a parameter, with a round counter, state machine and valid/ready handshakes on both sides.
- Sits between the bus-facing crypto wrapper (plaintext/key in) and the result buffer (ciphertext out).

---
 rtl/aes_pkg.sv | 107 ++++++++++
 rtl/aes_enc_iter_key_step.sv | 43 ++++
 rtl/aes_enc_iter.sv | 119 +++++++++++
 tb/tb_aes_enc_iter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and round helper functions
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

    // Forward S-box, entry 0 in the most significant byte
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic int nr_of(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

    // Round constant, 1-based; any index outside 1..10 yields 0
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic aes_word_t sub_word(input aes_word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic aes_state_t sub_bytes(input aes_state_t s);
        aes_state_t r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return r;
    endfunction

    // State is column-major: byte index = 4*col + row, byte 0 at [127:120]
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t r;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_enc_iter_key_step.sv
// rtl/aes_enc_iter_key_step.sv - combinational one-step AES key schedule (module aes_key_step)
module aes_key_step
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic [KEY_BITS-1:0] key_win,
    input  logic [3:0]          rnd,
    output logic [KEY_BITS-1:0] next_win,
    output logic [127:0]        round_key
);

    if (KEY_BITS == 256) begin : g_k256
        // Window holds {rk[rnd-1], rk[rnd]}; round rnd uses rk[rnd] and the window slides to rk[rnd+1]
        aes_word_t t, n0, n1, n2, n3;
        always_comb begin
            if (rnd[0]) begin
                t = sub_word(rot_word(key_win[31:0])) ^ {rcon_of(4'((rnd + 4'd1) >> 1)), 24'h0};
            end else begin
                t = sub_word(key_win[31:0]);
            end
            n0        = key_win[255:224] ^ t;
            n1        = key_win[223:192] ^ n0;
            n2        = key_win[191:160] ^ n1;
            n3        = key_win[159:128] ^ n2;
            next_win  = {key_win[127:0], n0, n1, n2, n3};
            round_key = key_win[127:0];
        end
    end else begin : g_k128
        // Window holds rk[rnd-1]; round rnd derives and uses rk[rnd]
        aes_word_t t, n0, n1, n2, n3;
        always_comb begin
            t         = sub_word(rot_word(key_win[31:0])) ^ {rcon_of(rnd), 24'h0};
            n0        = key_win[127:96] ^ t;
            n1        = key_win[95:64]  ^ n0;
            n2        = key_win[63:32]  ^ n1;
            n3        = key_win[31:0]   ^ n2;
            next_win  = {n0, n1, n2, n3};
            round_key = {n0, n1, n2, n3};
        end
    end

endmodule

// File: rtl/aes_enc_iter.sv
// rtl/aes_enc_iter.sv - iterative AES-128/256 encryptor, one round per clock; option AES_ENC_ZEROIZE_EN
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KEY_BITS-1:0] in_key,
    input  logic [127:0]        in_block,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_block,
    output logic                busy
);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_enc_iter: KEY_BITS must be 128 or 256");
    end

    localparam int         NR_INT = nr_of(KEY_BITS);
    localparam logic [3:0] NR     = 4'(NR_INT);

    aes_fsm_e            fsm_q,   fsm_d;
    aes_state_t          state_q, state_d;
    logic [KEY_BITS-1:0] key_q,   key_d;
    logic [3:0]          rnd_q,   rnd_d;

    logic [KEY_BITS-1:0] next_win;
    aes_state_t          round_key;
    aes_state_t          sb, sr, mc, round_out;

    aes_key_step #(.KEY_BITS(KEY_BITS)) u_key_step (
        .key_win   (key_q),
        .rnd       (rnd_q),
        .next_win  (next_win),
        .round_key (round_key)
    );

    // One full round; the final round skips MixColumns
    always_comb begin
        sb        = sub_bytes(state_q);
        sr        = shift_rows(sb);
        mc        = mix_columns(sr);
        round_out = ((rnd_q == NR) ? sr : mc) ^ round_key;
    end

    assign in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == RUN);

`ifdef AES_ENC_ZEROIZE_EN
    assign out_block = out_valid ? state_q : 128'h0;
`else
    assign out_block = state_q;
`endif

    // Next-state: load on input handshake, iterate rounds, hold result until taken
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_block ^ in_key[KEY_BITS-1 -: 128];
                    key_d   = in_key;
                    rnd_d   = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = round_out;
                key_d   = next_win;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == NR) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
`ifdef AES_ENC_ZEROIZE_EN
                    state_d = '0;
                    key_d   = '0;
                    rnd_d   = 4'd0;
`endif
                    fsm_d = IDLE;
                    // A block accepted on the same edge overrides any clear
                    if (in_valid) begin
                        state_d = in_block ^ in_key[KEY_BITS-1 -: 128];
                        key_d   = in_key;
                        rnd_d   = 4'd1;
                        fsm_d   = RUN;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State, datapath and key registers with async clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

endmodule

// File: tb/tb_aes_enc_iter.sv
// tb/tb_aes_enc_iter.sv - directed-vector bench for aes_enc_iter (128 and 256 instances)
module tb_aes_enc_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_key, in_block, out_block;

    logic         in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [255:0] in_key2;
    logic [127:0] in_block2, out_block2;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_enc_iter #(.KEY_BITS(128)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_block  (in_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    aes_enc_iter #(.KEY_BITS(256)) dut256 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_key    (in_key2),
        .in_block  (in_block2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_block (out_block2),
        .busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts at a negedge with the 128-bit engine idle; returns at the negedge where out_valid is seen
    task automatic run128(input logic [127:0] key, input logic [127:0] pt,
                          input logic [127:0] exp, input string tag);
        int cyc;
        cyc      = 0;
        in_key   = key;
        in_block = pt;
        in_valid = 1'b1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            cyc++;
            @(negedge clk);
        end
        check_eq({tag, "_latency"}, 128'(cyc - 1), 128'd10);
        check_eq({tag, "_ct"}, out_block, exp);
    endtask

    logic [127:0] keys [3];
    logic [127:0] pts  [3];
    logic [127:0] cts  [3];

    initial begin
        int cyc, idx, got, last, run_left;
        logic pending, exp_rdy, acc;
        logic [127:0] held;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_key     = '0;
        in_block   = '0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        in_key2    = '0;
        in_block2  = '0;
        out_ready2 = 1'b1;

        repeat (2) @(negedge clk);
        check_eq("rst_in_ready",  128'(in_ready),  128'd1);
        check_eq("rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("rst_busy",      128'(busy),      128'd0);
        check_eq("rst_out_block", out_block,       128'd0);
        check_eq("rst_in_ready256", 128'(in_ready2), 128'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // AES-128 known answer
        run128(KEY_C1, PT_C1, CT_C1, "aes128");
        @(negedge clk);
        check_eq("aes128_released", 128'(out_valid), 128'd0);

        // AES-256 known answer
        cyc       = 0;
        in_key2   = KEY_256;
        in_block2 = PT_C1;
        in_valid2 = 1'b1;
        while (!out_valid2 && cyc < 40) begin
            @(posedge clk);
            #1 in_valid2 = 1'b0;
            cyc++;
            @(negedge clk);
        end
        check_eq("aes256_latency", 128'(cyc - 1), 128'd14);
        check_eq("aes256_ct", out_block2, CT_256);
        @(negedge clk);

        // Back-to-back: three blocks with in_valid held high
        keys[0] = KEY_C1; pts[0] = PT_C1; cts[0] = CT_C1;
        keys[1] = KEY_B;  pts[1] = PT_B;  cts[1] = CT_B;
        keys[2] = '0;     pts[2] = '0;    cts[2] = CT_Z;
        idx = 0; got = 0; last = 0; run_left = 0; pending = 1'b0;
        in_key = keys[0]; in_block = pts[0]; in_valid = 1'b1;
        for (int c = 0; c < 60 && got < 3; c++) begin
            exp_rdy = (run_left == 0);
            check_eq("b2b_in_ready",  128'(in_ready),  128'(exp_rdy));
            check_eq("b2b_out_valid", 128'(out_valid), 128'(exp_rdy && pending));
            if (out_valid) begin
                check_eq("b2b_ct", out_block, cts[got]);
                if (got > 0) check_eq("b2b_spacing", 128'(c - last), 128'd11);
                last = c;
                got++;
                pending = 1'b0;
            end
            acc = in_valid && exp_rdy;
            @(posedge clk);
            #1;
            if (run_left > 0) run_left--;
            if (acc) begin
                run_left = 10;
                pending  = 1'b1;
                idx++;
                if (idx < 3) begin
                    in_key   = keys[idx];
                    in_block = pts[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        check_eq("b2b_count", 128'(got), 128'd3);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Backpressure: result held, inputs ignored
        out_ready = 1'b0;
        run128(KEY_B, PT_B, CT_B, "bp");
        held = CT_B;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            in_block = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_out_block", out_block,          held);
            check_eq("bp_in_ready",  128'(in_ready),     128'd0);
            check_eq("bp_out_valid", 128'(out_valid),    128'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1 check_eq("bp_release_ct", out_block, CT_B);
        @(negedge clk);
        check_eq("bp_release_valid", 128'(out_valid), 128'd0);

        // Reset in the middle of round 5
        in_key   = KEY_C1;
        in_block = PT_C1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("mid_busy_before", 128'(busy), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_out_valid", 128'(out_valid), 128'd0);
        check_eq("mid_busy",      128'(busy),      128'd0);
        check_eq("mid_in_ready",  128'(in_ready),  128'd1);
        check_eq("mid_out_block", out_block,       128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run128('0, '0, CT_Z, "post_rst");

        // Completion then idle: zeroize or hold
        @(negedge clk);
`ifdef AES_ENC_ZEROIZE_EN
        check_eq("zero_out_block", out_block, 128'd0);
        check_eq("zero_key_reg",   dut.key_q, 128'd0);
`else
        check_eq("hold_out_block", out_block, CT_Z);
`endif
        check_eq("idle_out_valid", 128'(out_valid), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
